// File: rtl/aes_ks_cache_if.sv
// aes_ks_cache_if: cipher-side and key-schedule-side signals of the round-key cache
interface aes_ks_cache_if;
  logic [255:0] key_i;
  logic [1:0] size_i;
  logic key_load_i;
  logic busy_o;
  logic ready_o;
  logic [3:0] nr_o;
  logic err_o;
  logic ks_load_o;
  logic ks_en_o;
  logic [1:0] ks_size_o;
  logic [255:0] ks_key_o;
  logic [127:0] ks_rk_i;
  logic rd_en_i;
  logic [3:0] rd_idx_i;
  logic [127:0] rd_rk_o;
  modport master (
    output key_i, size_i, key_load_i, ks_rk_i, rd_en_i, rd_idx_i,
    input busy_o, ready_o, nr_o, err_o, ks_load_o, ks_en_o, ks_size_o, ks_key_o, rd_rk_o
  );
  modport slave (
    input key_i, size_i, key_load_i, ks_rk_i, rd_en_i, rd_idx_i,
    output busy_o, ready_o, nr_o, err_o, ks_load_o, ks_en_o, ks_size_o, ks_key_o, rd_rk_o
  );
endinterface

// File: rtl/aes_ks_cache.sv
// aes_ks_cache: captures the AES key-schedule round keys once and serves them by index
module aes_ks_cache (
  input logic clk,
  input logic rst,
  aes_ks_cache_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, CAPTURE, READY} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] nr_q, nr_d;
  logic [127:0] rd_rk_q, rd_rk_d;
  logic [255:0] key_q, key_d;
  logic [1:0] size_q, size_d;
  logic err_q, err_d;
  logic [127:0] store [15];
  logic accept;
  logic rd_ok;
  assign accept = bus.key_load_i && bus.size_i != 2'd3;
  assign rd_ok = state_q == READY && bus.rd_idx_i <= nr_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    nr_d = nr_q;
    key_d = key_q;
    size_d = size_q;
    case (state_q)
      LOAD: begin
        state_d = CAPTURE;
        cnt_d = '0;
      end
      CAPTURE: begin
        state_d = cnt_q == nr_q ? READY : CAPTURE;
        cnt_d = cnt_q + 4'd1;
      end
      default: ;
    endcase
    if (accept) begin
      state_d = LOAD;
      key_d = bus.key_i;
      size_d = bus.size_i;
      nr_d = 4'd10 + {1'b0, bus.size_i, 1'b0};
    end
    err_d = (bus.key_load_i && !accept) || (bus.rd_en_i && !rd_ok);
    rd_rk_d = !bus.rd_en_i ? rd_rk_q : rd_ok ? store[bus.rd_idx_i] : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      nr_q <= '0;
      rd_rk_q <= '0;
      key_q <= '0;
      size_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      nr_q <= nr_d;
      rd_rk_q <= rd_rk_d;
      key_q <= key_d;
      size_q <= size_d;
      err_q <= err_d;
    end
  end
  // the store has no reset: reads are gated by READY, so stale slots never leak
  always_ff @(posedge clk) begin
    if (state_q == CAPTURE) store[cnt_q] <= bus.ks_rk_i;
  end
  assign bus.busy_o = state_q == LOAD || state_q == CAPTURE;
  assign bus.ready_o = state_q == READY;
  assign bus.nr_o = nr_q;
  assign bus.err_o = err_q;
  assign bus.ks_load_o = state_q == LOAD;
  assign bus.ks_en_o = state_q == CAPTURE && cnt_q != nr_q;
  assign bus.ks_size_o = size_q;
  assign bus.ks_key_o = key_q;
  assign bus.rd_rk_o = rd_rk_q;
endmodule

// File: tb/tb_aes_ks_cache.sv
// tb_aes_ks_cache: directed + random checks of the round-key cache against a FIPS-197 key expansion model
module tb_aes_ks_cache;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  aes_ks_cache_if bus();
  aes_ks_cache dut (.clk(clk), .rst(rst), .bus(bus));
  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  logic [7:0] sbox [256];
  logic [14:0][127:0] sched;
  logic [14:0][127:0] exp_rk;
  logic [3:0] sidx = '0;
  int n_assert = 0;
  int n_fail = 0;
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction
  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
  endfunction
  // FIPS-197 word-based key expansion; slots beyond Nr stay zero
  function automatic logic [14:0][127:0] expand(input logic [255:0] k, input logic [1:0] sz);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0] rc = 8'h01;
    int nk = 4 + 2 * int'(sz);
    int nr = nk + 6;
    logic [14:0][127:0] r = '0;
    for (int i = 0; i < 4 * (nr + 1); i++) begin
      if (i < nk) w[i] = k[255 - 32 * i -: 32];
      else begin
        t = w[i - 1];
        if (i % nk == 0) begin
          t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = xt(rc);
        end else if (nk == 8 && i % nk == 4) t = subw(t);
        w[i] = w[i - nk] ^ t;
      end
    end
    for (int j = 0; j <= nr; j++) r[j] = {w[4 * j], w[4 * j + 1], w[4 * j + 2], w[4 * j + 3]};
    return r;
  endfunction
  // behavioural key schedule: rk0 after the load edge, one step per enabled cycle
  always @(posedge clk) begin
    if (bus.ks_load_o) begin
      sched <= expand(bus.ks_key_o, bus.ks_size_o);
      sidx <= '0;
    end else if (bus.ks_en_o) sidx <= sidx + 4'd1;
  end
  assign bus.ks_rk_i = sidx > 4'd14 ? '0 : sched[sidx];
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] want);
    n_assert++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic drive_load(input logic [255:0] k, input logic [1:0] sz);
    bus.key_load_i = 1'b1;
    bus.key_i = k;
    bus.size_i = sz;
    tick();
    bus.key_load_i = 1'b0;
  endtask
  task automatic wait_fill(input string tag, input int want_c, input int want_nr);
    int c = 0;
    int en = 0;
    while (bus.ready_o !== 1'b1 && c < 40) begin
      en += int'(bus.ks_en_o);
      tick();
      c++;
    end
    chk({tag, "_ready_cycles"}, 256'(c), 256'(want_c));
    chk({tag, "_en_cycles"}, 256'(en), 256'(want_nr));
    chk({tag, "_busy_done"}, 256'(bus.busy_o), 256'(0));
  endtask
  task automatic load_fill(input logic [255:0] k, input logic [1:0] sz, input string tag);
    int nr = 10 + 2 * int'(sz);
    drive_load(k, sz);
    chk({tag, "_ks_load"}, 256'(bus.ks_load_o), 256'(1));
    chk({tag, "_busy"}, 256'(bus.busy_o), 256'(1));
    chk({tag, "_ready_low"}, 256'(bus.ready_o), 256'(0));
    chk({tag, "_ks_key"}, bus.ks_key_o, k);
    chk({tag, "_ks_size"}, 256'(bus.ks_size_o), 256'(sz));
    chk({tag, "_nr"}, 256'(bus.nr_o), 256'(nr));
    wait_fill(tag, nr + 2, nr);
    exp_rk = expand(k, sz);
  endtask
  task automatic rd(input logic [3:0] idx, input logic [127:0] want, input logic want_err, input string tag);
    bus.rd_en_i = 1'b1;
    bus.rd_idx_i = idx;
    tick();
    bus.rd_en_i = 1'b0;
    chk({tag, "_data"}, 256'(bus.rd_rk_o), 256'(want));
    chk({tag, "_err"}, 256'(bus.err_o), 256'(want_err));
  endtask
  initial begin
    logic [255:0] rk;
    logic [1:0] rsz;
    int rnr;
    int off;
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = '0;
      logic [7:0] s;
      for (int b = 1; b < 256; b++) if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      s = inv ^ 8'h63;
      for (int j = 1; j <= 4; j++) s ^= 8'({inv, inv} >> (8 - j));
      sbox[a] = s;
    end
    bus.key_i = '0;
    bus.size_i = '0;
    bus.key_load_i = 1'b0;
    bus.rd_en_i = 1'b0;
    bus.rd_idx_i = '0;
    tick();
    chk("rst_ready", 256'(bus.ready_o), 256'(0));
    chk("rst_busy", 256'(bus.busy_o), 256'(0));
    chk("rst_nr", 256'(bus.nr_o), 256'(0));
    chk("rst_err", 256'(bus.err_o), 256'(0));
    chk("rst_rd_rk", 256'(bus.rd_rk_o), 256'(0));
    chk("rst_ks_load", 256'(bus.ks_load_o), 256'(0));
    chk("rst_ks_en", 256'(bus.ks_en_o), 256'(0));
    chk("rst_ks_key", bus.ks_key_o, 256'(0));
    chk("rst_ks_size", 256'(bus.ks_size_o), 256'(0));
    rst = 1'b0;
    tick();
    rd(4'd0, '0, 1'b1, "rd_idle");
    load_fill(K128, 2'd0, "aes128");
    rd(4'd1, 128'ha0fafe1788542cb123a339392a6c7605, 1'b0, "aes128_idx1");
    rd(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b0, "aes128_idx10");
    for (int i = 0; i <= 10; i++) rd(4'(i), exp_rk[i], 1'b0, $sformatf("aes128_model_%0d", i));
    rd(4'd11, '0, 1'b1, "rd_idx11");
    tick();
    chk("rd_idx11_err_pulse", 256'(bus.err_o), 256'(0));
    chk("rd_hold", 256'(bus.rd_rk_o), 256'(0));
    drive_load(K256, 2'd3);
    chk("bad_load_err", 256'(bus.err_o), 256'(1));
    chk("bad_load_ready", 256'(bus.ready_o), 256'(1));
    chk("bad_load_busy", 256'(bus.busy_o), 256'(0));
    chk("bad_load_nr", 256'(bus.nr_o), 256'(10));
    chk("bad_load_key", bus.ks_key_o, K128);
    tick();
    chk("bad_load_err_pulse", 256'(bus.err_o), 256'(0));
    rd(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b0, "bad_load_idx10");
    bus.key_load_i = 1'b1;
    bus.size_i = 2'd3;
    bus.rd_en_i = 1'b1;
    bus.rd_idx_i = 4'd12;
    tick();
    bus.key_load_i = 1'b0;
    bus.rd_en_i = 1'b0;
    chk("dual_err", 256'(bus.err_o), 256'(1));
    tick();
    chk("dual_err_single", 256'(bus.err_o), 256'(0));
    load_fill(K192, 2'd1, "aes192");
    rd(4'd12, 128'he98ba06f448c773c8ecc720401002202, 1'b0, "aes192_idx12");
    rd(4'd13, '0, 1'b1, "aes192_idx13");
    load_fill(K256, 2'd2, "aes256");
    rd(4'd14, 128'hfe4890d1e6188d0b046df344706c631e, 1'b0, "aes256_idx14");
    bus.rd_en_i = 1'b1;
    for (int i = 14; i >= 0; i--) begin
      bus.rd_idx_i = 4'(i);
      tick();
      chk($sformatf("sweep_%0d", i), 256'(bus.rd_rk_o), 256'(exp_rk[i]));
      chk($sformatf("sweep_err_%0d", i), 256'(bus.err_o), 256'(0));
    end
    bus.rd_en_i = 1'b0;
    chk("sweep_idx0", 256'(bus.rd_rk_o), 256'(128'h603deb1015ca71be2b73aef0857d7781));
    bus.key_load_i = 1'b1;
    bus.key_i = K128;
    bus.size_i = 2'd0;
    bus.rd_en_i = 1'b1;
    bus.rd_idx_i = 4'd3;
    tick();
    bus.key_load_i = 1'b0;
    bus.rd_en_i = 1'b0;
    chk("rd_at_load_data", 256'(bus.rd_rk_o), 256'(exp_rk[3]));
    chk("rd_at_load_err", 256'(bus.err_o), 256'(0));
    rd(4'd0, '0, 1'b1, "rd_in_fill");
    wait_fill("rd_at_load", 11, 10);
    exp_rk = expand(K128, 2'd0);
    rd(4'd10, exp_rk[10], 1'b0, "rd_at_load_idx10");
    drive_load(K128, 2'd0);
    repeat (4) tick();
    drive_load(K256, 2'd2);
    wait_fill("restart", 16, 14);
    exp_rk = expand(K256, 2'd2);
    for (int i = 0; i <= 14; i++) rd(4'(i), exp_rk[i], 1'b0, $sformatf("restart_%0d", i));
    drive_load(K192, 2'd1);
    repeat (3) tick();
    chk("pre_rst_ks_en", 256'(bus.ks_en_o), 256'(1));
    #2 rst = 1'b1;
    #1;
    chk("arst_ks_en", 256'(bus.ks_en_o), 256'(0));
    chk("arst_ks_load", 256'(bus.ks_load_o), 256'(0));
    chk("arst_busy", 256'(bus.busy_o), 256'(0));
    chk("arst_ready", 256'(bus.ready_o), 256'(0));
    chk("arst_nr", 256'(bus.nr_o), 256'(0));
    chk("arst_rd_rk", 256'(bus.rd_rk_o), 256'(0));
    chk("arst_ks_key", bus.ks_key_o, 256'(0));
    tick();
    rst = 1'b0;
    rd(4'd0, '0, 1'b1, "rd_after_rst");
    load_fill(K128, 2'd0, "post_rst");
    rd(4'd1, 128'ha0fafe1788542cb123a339392a6c7605, 1'b0, "post_rst_idx1");
    repeat (6) begin
      rsz = 2'($urandom_range(0, 2));
      rnr = 10 + 2 * int'(rsz);
      for (int j = 0; j < 8; j++) rk[32 * j +: 32] = $urandom();
      load_fill(rk, rsz, "rand");
      off = $urandom_range(0, rnr);
      for (int i = 0; i <= rnr; i++) rd(4'((i + off) % (rnr + 1)), exp_rk[(i + off) % (rnr + 1)], 1'b0, $sformatf("rand_rd_%0d", (i + off) % (rnr + 1)));
      rd(4'($urandom_range(rnr + 1, 15)), '0, 1'b1, "rand_bad_idx");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
